// File: rtl/guess_split.sv
// guess_split: consumer of the minimum-possibility search.
//
// Accepts a 729-bit candidate grid (81 cells x 9 candidate bits), drives it to
// the min-search stage, waits out that stage's pipeline latency, samples the
// returned (minPoss, minIdx) and classifies the grid as guess / solved / dead.
// For a branchable grid it produces a guess child (chosen cell forced to its
// lowest candidate) and a rest child (that candidate removed).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input handshake, in_grid = candidate grid
//   mp_grid         grid presented to the min-search stage (held until next accept)
//   mp_minPoss/Idx  min-search results (minPoss 15 = all singletons)
//   out_valid/ready output handshake
//   out_status      0 = guess, 1 = solved, 2 = dead
//   out_idx         branched cell index
//   out_guess/rest  child grids
//
// state | meaning
// IDLE  | in_ready high, waiting for a grid
// WAIT  | down-counting the min-search latency
// EVAL  | sampled (minPoss, minIdx) held, results computed and registered
// OUT   | out_valid high until out_ready

module guess_split #(
    parameter int MP_LATENCY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [728:0] in_grid,
    output logic [728:0] mp_grid,
    input  logic [3:0]   mp_minPoss,
    input  logic [6:0]   mp_minIdx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_status,
    output logic [6:0]   out_idx,
    output logic [728:0] out_guess,
    output logic [728:0] out_rest
);

    localparam int CW = $clog2(MP_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MP_LATENCY - 1);

    localparam logic [1:0] ST_GUESS  = 2'd0;
    localparam logic [1:0] ST_SOLVED = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT, EVAL, OUT} state_t;

    state_t          state;
    logic [CW-1:0]   waitCnt;
    logic [3:0]      sampPoss;
    logic [6:0]      sampIdx;

    logic [8:0]      selCell;
    logic [8:0]      lowBit;
    logic [1:0]      nextStatus;
    logic [728:0]    nextGuess;
    logic [728:0]    nextRest;

    // Result datapath, driven from the sampled search outputs and the held grid.
    // The cell select compares against each of the 81 legal indices only, so an
    // out-of-range index selects nothing and no field outside 0..80 exists.
    always_comb begin
        selCell    = '0;
        nextStatus = ST_GUESS;
        nextGuess  = mp_grid;
        nextRest   = mp_grid;

        for (int i = 0; i < 81; i++) begin
            if (sampIdx == 7'(i)) begin
                selCell = mp_grid[9*i +: 9];
            end
        end

        // Two's-complement trick isolates the lowest set candidate bit.
        lowBit = selCell & (~selCell + 9'd1);

        if (sampPoss == 4'd0) begin
            nextStatus = ST_DEAD;
        end else if (sampPoss == 4'd15) begin
            nextStatus = ST_SOLVED;
        end else if (sampIdx > 7'd80) begin
            nextStatus = ST_DEAD;
        end else begin
            nextStatus = ST_GUESS;
        end

        if (nextStatus == ST_GUESS) begin
            for (int i = 0; i < 81; i++) begin
                if (sampIdx == 7'(i)) begin
                    nextGuess[9*i +: 9] = lowBit;
                    nextRest[9*i +: 9]  = selCell & ~lowBit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            waitCnt    <= '0;
            sampPoss   <= '0;
            sampIdx    <= '0;
            mp_grid    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_status <= ST_GUESS;
            out_idx    <= '0;
            out_guess  <= '0;
            out_rest   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mp_grid  <= in_grid;
                        waitCnt  <= CNT_LOAD;
                        in_ready <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Search outputs are sampled only on the edge leaving WAIT.
                    if (waitCnt == '0) begin
                        sampPoss <= mp_minPoss;
                        sampIdx  <= mp_minIdx;
                        state    <= EVAL;
                    end else begin
                        waitCnt <= waitCnt - CW'(1);
                    end
                end
                EVAL: begin
                    out_status <= nextStatus;
                    out_idx    <= sampIdx;
                    out_guess  <= nextGuess;
                    out_rest   <= nextRest;
                    out_valid  <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    // No accept in this cycle; in_ready rises only once back in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guess_split.sv
// Directed self-checking bench for guess_split. The accepting edge is counted as
// the first edge; out_valid must be seen after the fifth edge of that count.
module tb_guess_split;

    localparam int MP_LATENCY = 3;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [728:0] in_grid;
    logic [728:0] mp_grid;
    logic [3:0]   mp_minPoss;
    logic [6:0]   mp_minIdx;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_status;
    logic [6:0]   out_idx;
    logic [728:0] out_guess;
    logic [728:0] out_rest;

    int checks = 0;
    int errors = 0;

    logic [728:0] base;

    guess_split #(.MP_LATENCY(MP_LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_grid    (in_grid),
        .mp_grid    (mp_grid),
        .mp_minPoss (mp_minPoss),
        .mp_minIdx  (mp_minIdx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_status (out_status),
        .out_idx    (out_idx),
        .out_guess  (out_guess),
        .out_rest   (out_rest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [728:0] setCell(input logic [728:0] g, input int idx, input logic [8:0] v);
        logic [728:0] r;
        r = g;
        r[9*idx +: 9] = v;
        return r;
    endfunction

    // Waits (bounded) for in_ready, then presents one grid for a single accepting edge.
    task automatic acceptGrid(input logic [728:0] g);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_grid  = g;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_grid  = ~g;
    endtask

    // Counts edges after the accepting edge until out_valid; 99 marks a timeout.
    task automatic waitValid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid !== 1'b1) n = 99;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_grid = '1; out_ready = 1'b1;
        mp_minPoss = 4'd2; mp_minIdx = 7'd5;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (out_status !== 2'd0 || out_idx !== 7'd0) begin
            errors++;
            $display("FAIL reset_status: status=%0d idx=%0d required 0/0", out_status, out_idx);
        end
        checks++;
        if (out_guess !== '0 || out_rest !== '0 || mp_grid !== '0) begin
            errors++;
            $display("FAIL reset_grids: guess/rest/mp_grid not all zero");
        end
        #19 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_guess;
        logic [728:0] g;
        int early;
        g = setCell(base, 5, 9'h0A0);
        mp_minPoss = 4'd2; mp_minIdx = 7'd5; out_ready = 1'b1;
        acceptGrid(g);
        checks++;
        if (mp_grid !== g) begin
            errors++;
            $display("FAIL guess_capture: mp_grid=%h required %h", mp_grid, g);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL guess_busy: in_ready=%b required 0", in_ready);
        end
        early = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) early++;
        end
        // Search inputs have been sampled; changing them now must not matter.
        mp_minPoss = 4'd0; mp_minIdx = 7'd0;
        @(posedge clk); #1;
        checks++;
        if (early != 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL guess_latency: early=%0d out_valid=%b required 0/1 on 5th edge", early, out_valid);
        end
        checks++;
        if (out_status !== 2'd0 || out_idx !== 7'd5) begin
            errors++;
            $display("FAIL guess_status: status=%0d idx=%0d required 0/5", out_status, out_idx);
        end
        checks++;
        if (out_guess !== setCell(g, 5, 9'h020)) begin
            errors++;
            $display("FAIL guess_grid: cell5=%h required 020", out_guess[45 +: 9]);
        end
        checks++;
        if (out_rest !== setCell(g, 5, 9'h080)) begin
            errors++;
            $display("FAIL guess_rest: cell5=%h required 080", out_rest[45 +: 9]);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL guess_return: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_solved_dead;
        logic [3:0] pTab [4] = '{4'd15, 4'd0, 4'd3, 4'd3};
        logic [6:0] kTab [4] = '{7'd12, 7'd7, 7'd81, 7'd127};
        logic [1:0] sTab [4] = '{2'd1, 2'd2, 2'd2, 2'd2};
        logic [728:0] g;
        int n;
        for (int t = 0; t < 4; t++) begin
            g = setCell(base, 20 + t, 9'h0F0);
            mp_minPoss = pTab[t]; mp_minIdx = kTab[t];
            acceptGrid(g);
            waitValid(n);
            checks++;
            if (n != 4) begin
                errors++;
                $display("FAIL sd_latency[%0d]: edges=%0d required 4 after accept", t, n);
            end
            checks++;
            if (out_status !== sTab[t] || out_idx !== kTab[t]) begin
                errors++;
                $display("FAIL sd_status[%0d]: status=%0d idx=%0d required %0d/%0d", t, out_status, out_idx, sTab[t], kTab[t]);
            end
            checks++;
            if (out_guess !== g || out_rest !== g) begin
                errors++;
                $display("FAIL sd_passthru[%0d]: guess or rest differs from input grid", t);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [728:0] g;
        int spurious;
        int n;
        mp_minPoss = 4'd2; mp_minIdx = 7'd5;
        acceptGrid(setCell(base, 3, 9'h011));
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_status !== 2'd0 || out_idx !== 7'd0) begin
            errors++;
            $display("FAIL midreset_ctrl: in_ready=%b out_valid=%b status=%0d idx=%0d required 1/0/0/0",
                     in_ready, out_valid, out_status, out_idx);
        end
        checks++;
        if (out_guess !== '0 || out_rest !== '0 || mp_grid !== '0) begin
            errors++;
            $display("FAIL midreset_grids: guess/rest/mp_grid not all zero");
        end
        #3 rst = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midreset_spurious: out_valid high %0d cycles required 0", spurious);
        end
        g = setCell(base, 3, 9'h011);
        mp_minPoss = 4'd2; mp_minIdx = 7'd3;
        acceptGrid(g);
        waitValid(n);
        checks++;
        if (n != 4 || out_status !== 2'd0 || out_guess !== setCell(g, 3, 9'h001) || out_rest !== setCell(g, 3, 9'h010)) begin
            errors++;
            $display("FAIL midreset_after: edges=%0d status=%0d guess3=%h rest3=%h required 4/0/001/010",
                     n, out_status, out_guess[27 +: 9], out_rest[27 +: 9]);
        end
    endtask

    task automatic test_backpressure;
        logic [728:0] g;
        int n;
        int bad;
        g = setCell(base, 40, 9'h00C);
        mp_minPoss = 4'd2; mp_minIdx = 7'd40;
        acceptGrid(g);
        out_ready = 1'b0;
        waitValid(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_latency: edges=%0d required 4", n);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_grid  = ~base;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mp_grid !== g || out_status !== 2'd0 ||
                out_idx !== 7'd40 || out_guess !== setCell(g, 40, 9'h004) || out_rest !== setCell(g, 40, 9'h008))
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mp_grid !== g) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b mp_grid_kept=%b required 1/0/1",
                     in_ready, out_valid, (mp_grid === g));
        end
    endtask

    task automatic test_edge_cells;
        logic [728:0] g;
        int n;
        g = setCell(base, 0, 9'h1FF);
        mp_minPoss = 4'd9; mp_minIdx = 7'd0;
        acceptGrid(g);
        waitValid(n);
        checks++;
        if (n != 4 || out_status !== 2'd0 || out_idx !== 7'd0) begin
            errors++;
            $display("FAIL edge0_status: edges=%0d status=%0d idx=%0d required 4/0/0", n, out_status, out_idx);
        end
        checks++;
        if (out_guess !== setCell(g, 0, 9'h001) || out_rest !== setCell(g, 0, 9'h1FE)) begin
            errors++;
            $display("FAIL edge0_grids: guess0=%h rest0=%h required 001/1FE", out_guess[8:0], out_rest[8:0]);
        end
        g = setCell(base, 80, 9'h100);
        mp_minPoss = 4'd2; mp_minIdx = 7'd80;
        acceptGrid(g);
        waitValid(n);
        checks++;
        if (n != 4 || out_status !== 2'd0 || out_idx !== 7'd80) begin
            errors++;
            $display("FAIL edge80_status: edges=%0d status=%0d idx=%0d required 4/0/80", n, out_status, out_idx);
        end
        checks++;
        if (out_guess !== setCell(g, 80, 9'h100) || out_rest !== setCell(g, 80, 9'h000)) begin
            errors++;
            $display("FAIL edge80_grids: guess80=%h rest80=%h required 100/000", out_guess[728:720], out_rest[728:720]);
        end
    endtask

    task automatic test_back_to_back;
        logic [728:0] g1;
        logic [728:0] g2;
        int n;
        int gap;
        g1 = setCell(base, 60, 9'h006);
        g2 = setCell(base, 61, 9'h180);
        out_ready = 1'b1;
        mp_minPoss = 4'd2; mp_minIdx = 7'd60;
        acceptGrid(g1);
        waitValid(n);
        checks++;
        if (out_guess !== setCell(g1, 60, 9'h002) || out_rest !== setCell(g1, 60, 9'h004)) begin
            errors++;
            $display("FAIL b2b_first: guess60=%h rest60=%h required 002/004", out_guess[540 +: 9], out_rest[540 +: 9]);
        end
        gap = n;
        while (in_ready !== 1'b1 && gap < 30) begin
            @(posedge clk); #1;
            gap++;
        end
        checks++;
        if (gap != 5) begin
            errors++;
            $display("FAIL b2b_gap: in_ready back after %0d edges required 5", gap);
        end
        mp_minIdx = 7'd61;
        acceptGrid(g2);
        waitValid(n);
        checks++;
        if (n != 4 || out_idx !== 7'd61 || out_guess !== setCell(g2, 61, 9'h080) || out_rest !== setCell(g2, 61, 9'h100)) begin
            errors++;
            $display("FAIL b2b_second: edges=%0d idx=%0d guess61=%h rest61=%h required 4/61/080/100",
                     n, out_idx, out_guess[549 +: 9], out_rest[549 +: 9]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 81; i++) begin
            base[9*i +: 9] = 9'((i * 37 + 11) % 512);
        end
        test_reset();
        test_guess();
        test_solved_dead();
        test_reset_mid();
        test_backpressure();
        test_edge_cells();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
